// File: rtl/pwm_tone_scheduler_if.sv
// pwm_tone_scheduler_if
// Requester-side and generator-side signals of the PWM tone scheduler.
// The slave modport is the scheduler's view. The master modport is the view of
// the sequencer plus generator environment that drives it.
interface pwm_tone_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 8,
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 16
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_duty;
  logic [NUM_REQ*DIV_W-1:0]     req_div;
  logic [NUM_REQ*DUR_W-1:0]     req_dur;
  logic                         gen_period_tick;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic                         gen_load;
  logic                         gen_en;
  logic [BIT_WIDTH-1:0]         gen_duty;
  logic [DIV_W-1:0]             gen_div;

  modport master (
    output req, req_duty, req_div, req_dur, gen_period_tick,
    input  grant, done, busy, gen_load, gen_en, gen_duty, gen_div
  );

  modport slave (
    input  req, req_duty, req_div, req_dur, gen_period_tick,
    output grant, done, busy, gen_load, gen_en, gen_duty, gen_div
  );
endinterface

// File: rtl/pwm_tone_scheduler.sv
// pwm_tone_scheduler
// Time-shares one PWM tone generator between NUM_REQ requesters. It arbitrates,
// loads the winner's duty/divider, runs for the requested number of PWM periods,
// then releases the generator. An owner that drops req stops at the next period
// boundary. A completing tick always produces a done pulse.
// Build option: define PWM_SCHED_FIXED_PRIO_EN for fixed priority (lowest index
// wins, rr_ptr held at 0). Round-robin is the default.
module pwm_tone_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 8,
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  pwm_tone_scheduler_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W + 1)'(NUM_REQ);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1'b1);
  localparam logic [DUR_W-1:0] DUR_ZERO  = {DUR_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [PTR_W-1:0]       rr_ptr_r, own_r, own_nxt_s, base_s, win_idx_s, cand_s;
  logic [PTR_W:0]         sum_s;
  logic                   win_found_s;
  logic [DUR_W-1:0]       dur_r, cnt_r;
  logic                   abort_r, abort_s, last_tick_s;
  logic [NUM_REQ-1:0]     grant_r, done_r, grant_nxt_s, done_nxt_s;
  logic                   busy_r, gen_load_r, gen_en_r;
  logic                   busy_nxt_s, gen_load_nxt_s, gen_en_nxt_s;
  logic [BIT_WIDTH-1:0]   gen_duty_r;
  logic [DIV_W-1:0]       gen_div_r;
  logic [BIT_WIDTH-1:0]   duty_a [NUM_REQ];
  logic [DIV_W-1:0]       div_a  [NUM_REQ];
  logic [DUR_W-1:0]       dur_a  [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign duty_a[g] = bus.req_duty[g*BIT_WIDTH +: BIT_WIDTH];
    assign div_a[g]  = bus.req_div[g*DIV_W +: DIV_W];
    assign dur_a[g]  = bus.req_dur[g*DUR_W +: DUR_W];
  end

`ifdef PWM_SCHED_FIXED_PRIO_EN
  assign base_s = {PTR_W{1'b0}};
`else
  assign base_s = rr_ptr_r;
`endif

  // Latched abort, or the owner dropping req right now. This covers a drop in the tick cycle itself.
  assign abort_s     = abort_r | ~bus.req[own_r];
  assign last_tick_s = ((cnt_r + DUR_ONE) == dur_r);

  // Winner search: first requesting index scanning upward from base_s, wrapping modulo NUM_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    sum_s       = {(PTR_W + 1){1'b0}};
    cand_s      = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, base_s} + (PTR_W + 1)'(k);
      if (sum_s >= NUM_REQ_X) begin
        sum_s = sum_s - NUM_REQ_X;
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PTR_W-1:0];
      if (!win_found_s && bus.req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic of the scheduler FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (|bus.req) state_nxt_s = S_ARB;
        else          state_nxt_s = S_IDLE;
      end
      S_ARB: begin
        if (win_found_s) state_nxt_s = S_LOAD;
        else             state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (dur_r == DUR_ZERO) state_nxt_s = S_DONE;
        else                   state_nxt_s = S_RUN;
      end
      S_RUN: begin
        if (bus.gen_period_tick) begin
          if (last_tick_s)  state_nxt_s = S_DONE;
          else if (abort_s) state_nxt_s = S_IDLE;
          else              state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    grant_nxt_s    = {NUM_REQ{1'b0}};
    done_nxt_s     = {NUM_REQ{1'b0}};
    busy_nxt_s     = 1'b0;
    gen_load_nxt_s = 1'b0;
    gen_en_nxt_s   = 1'b0;
    if (state_r == S_ARB) own_nxt_s = win_idx_s;
    else                  own_nxt_s = own_r;
    case (state_nxt_s)
      S_IDLE: busy_nxt_s = 1'b0;
      S_ARB:  busy_nxt_s = 1'b1;
      S_LOAD: begin
        busy_nxt_s     = 1'b1;
        grant_nxt_s    = to_onehot(own_nxt_s);
        gen_load_nxt_s = 1'b1;
      end
      S_RUN: begin
        busy_nxt_s   = 1'b1;
        grant_nxt_s  = to_onehot(own_nxt_s);
        gen_en_nxt_s = 1'b1;
      end
      S_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = to_onehot(own_nxt_s);
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // State, owner, configuration latch, period counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      own_r      <= {PTR_W{1'b0}};
      dur_r      <= DUR_ZERO;
      cnt_r      <= DUR_ZERO;
      abort_r    <= 1'b0;
      grant_r    <= {NUM_REQ{1'b0}};
      done_r     <= {NUM_REQ{1'b0}};
      busy_r     <= 1'b0;
      gen_load_r <= 1'b0;
      gen_en_r   <= 1'b0;
      gen_duty_r <= {BIT_WIDTH{1'b0}};
      gen_div_r  <= {DIV_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      own_r      <= own_nxt_s;
      grant_r    <= grant_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      gen_load_r <= gen_load_nxt_s;
      gen_en_r   <= gen_en_nxt_s;
      if (state_r == S_ARB && win_found_s) begin
        dur_r      <= dur_a[win_idx_s];
        gen_duty_r <= duty_a[win_idx_s];
        gen_div_r  <= div_a[win_idx_s];
      end
      if (state_r == S_LOAD) begin
        cnt_r   <= DUR_ZERO;
        abort_r <= 1'b0;
`ifdef PWM_SCHED_FIXED_PRIO_EN
        rr_ptr_r <= {PTR_W{1'b0}};
`else
        rr_ptr_r <= (own_r == LAST_IDX) ? {PTR_W{1'b0}} : (own_r + PTR_ONE);
`endif
      end else if (state_r == S_RUN) begin
        if (bus.gen_period_tick) cnt_r <= cnt_r + DUR_ONE;
        if (!bus.req[own_r])     abort_r <= 1'b1;
      end
    end
  end

  assign bus.grant    = grant_r;
  assign bus.done     = done_r;
  assign bus.busy     = busy_r;
  assign bus.gen_load = gen_load_r;
  assign bus.gen_en   = gen_en_r;
  assign bus.gen_duty = gen_duty_r;
  assign bus.gen_div  = gen_div_r;
endmodule

// File: tb/tb_pwm_tone_scheduler.sv
// tb_pwm_tone_scheduler
// Self-checking bench for pwm_tone_scheduler. A transaction-level model predicts
// each grant from the arbitration rule, plus the loaded fields, the ticks consumed,
// the completion/abort outcome and the load latency.
// Inputs change and outputs are read on the falling clock edge.
module tb_pwm_tone_scheduler;
  localparam int NR = 4;
  localparam int BW = 8;
  localparam int DW = 16;
  localparam int UW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_tone_scheduler_if #(.NUM_REQ(NR), .BIT_WIDTH(BW), .DIV_W(DW), .DUR_W(UW)) bus ();
  pwm_tone_scheduler #(.NUM_REQ(NR), .BIT_WIDTH(BW), .DIV_W(DW), .DUR_W(UW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_per = 3;
  int phase    = 0;
  int m_ptr    = 0;
  int m_lat    = 2;
  logic [BW-1:0] f_duty [NR];
  logic [DW-1:0] f_div  [NR];
  logic [UW-1:0] f_dur  [NR];

  int o_w, o_ticks, o_en, o_lat, o_gap;
  bit o_abort, o_tmo;
  logic [NR-1:0] o_grant, o_done;
  logic [BW-1:0] o_duty;
  logic [DW-1:0] o_div;

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] v;
    v = '0;
    if (w >= 0 && w < NR) v[w] = 1'b1;
    return v;
  endfunction

  // Arbitration rule: first requester scanning from the pointer (or from 0 with fixed priority).
  function automatic int model_winner(input logic [NR-1:0] r);
    int idx;
`ifdef PWM_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (tick_per <= 0) begin
      bus.gen_period_tick = 1'b0;
    end else begin
      phase = (phase + 1) % tick_per;
      bus.gen_period_tick = (phase == 0);
    end
  endtask

  task automatic pack();
    for (int j = 0; j < NR; j++) begin
      bus.req_duty[j*BW +: BW] = f_duty[j];
      bus.req_div[j*DW +: DW]  = f_div[j];
      bus.req_dur[j*UW +: UW]  = f_dur[j];
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    cyc();
    cyc();
    reset = 1'b0;
    m_ptr = 0;
    m_lat = 2;
  endtask

  // Observe one generator ownership: the load, then the run until done or release.
  task automatic observe(input int drop_at, input bit drop_on_done);
    int n;
    int since;
    bit fin;
    o_w = -1; o_ticks = 0; o_en = 0; o_lat = 0; o_gap = 0; o_abort = 0; o_tmo = 0;
    o_grant = '0; o_done = '0; o_duty = '0; o_div = '0;
    n = 0; fin = 0;
    while (!fin) begin
      cyc(); n++;
      if (bus.gen_load) begin
        fin = 1; o_lat = n; o_grant = bus.grant; o_duty = bus.gen_duty; o_div = bus.gen_div;
        for (int j = NR - 1; j >= 0; j--) if (bus.grant[j]) o_w = j;
      end else if (n >= 100) begin
        fin = 1; o_tmo = 1;
      end
    end
    fin = o_tmo;
    since = 1000;
    while (!fin) begin
      if (bus.gen_en) o_en++;
      if (bus.gen_en && bus.gen_period_tick) begin
        if (drop_at >= 0 && o_ticks == drop_at && o_w >= 0) bus.req[o_w] = 1'b0;
        o_ticks++; since = 0;
      end
      cyc(); n++; since++;
      if (bus.done != '0) begin
        fin = 1; o_done = bus.done; o_gap = since;
        if (drop_on_done && o_w >= 0) bus.req[o_w] = 1'b0;
      end else if (!bus.busy) begin
        fin = 1; o_abort = 1;
      end else if (n >= 400) begin
        fin = 1; o_tmo = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0; bus.req_duty = '0; bus.req_div = '0; bus.req_dur = '0;
    bus.gen_period_tick = 1'b0;
    cyc(); cyc();
    n_checks++;
    if ({bus.grant, bus.done, bus.busy, bus.gen_load, bus.gen_en, bus.gen_duty, bus.gen_div} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got grant=%b done=%b busy=%b load=%b en=%b duty=%0d div=%0d want all 0",
        bus.grant, bus.done, bus.busy, bus.gen_load, bus.gen_en, bus.gen_duty, bus.gen_div);
    end
    reset = 1'b0; m_ptr = 0; m_lat = 2;
  endtask

  task automatic test_single();
    f_duty[0] = 8'd64; f_div[0] = 16'd195; f_dur[0] = 16'd3; pack();
    tick_per = 3;
    bus.req = 4'b0001;
    observe(-1, 1'b1);
    n_checks++; if (o_tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %0b want 0", o_tmo); end
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL single_load_latency: got %0d want 2", o_lat); end
    n_checks++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", o_grant); end
    n_checks++; if (o_duty !== 8'd64) begin n_fail++; $display("FAIL single_duty: got %0d want 64", o_duty); end
    n_checks++; if (o_div !== 16'd195) begin n_fail++; $display("FAIL single_div: got %0d want 195", o_div); end
    n_checks++; if (o_ticks !== 3) begin n_fail++; $display("FAIL single_ticks: got %0d want 3", o_ticks); end
    n_checks++; if (o_done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", o_done); end
    n_checks++; if (o_gap !== 1) begin n_fail++; $display("FAIL single_done_delay: got %0d want 1", o_gap); end
    n_checks++; if (bus.grant !== 4'b0000 || bus.gen_en !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got grant=%b en=%b want 0000/0", bus.grant, bus.gen_en); end
    m_ptr = 1; m_lat = 3;
    cyc(); cyc();
    m_lat = 2;
  endtask

  task automatic test_round_robin();
    int ew;
    do_reset();
    tick_per = 2;
    for (int j = 0; j < NR; j++) begin f_duty[j] = BW'(j * 10 + 5); f_div[j] = DW'(j + 100); f_dur[j] = 16'd1; end
    pack();
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      ew = model_winner(bus.req);
      observe(-1, 1'b0);
      n_checks++; if (o_tmo !== 1'b0) begin n_fail++; $display("FAIL rr_timeout[%0d]: got %0b want 0", t, o_tmo); end
      n_checks++; if (o_grant !== onehot(ew)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", t, o_grant, onehot(ew)); end
      n_checks++; if (o_done !== onehot(ew)) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", t, o_done, onehot(ew)); end
      n_checks++; if (o_lat !== m_lat) begin n_fail++; $display("FAIL rr_latency[%0d]: got %0d want %0d", t, o_lat, m_lat); end
      m_ptr = (ew + 1) % NR; m_lat = 3;
    end
    bus.req = '0;
    cyc(); cyc(); cyc();
    m_lat = 2;
  endtask

  task automatic test_dur_zero();
    int ew;
    f_duty[2] = 8'd200; f_div[2] = 16'd7; f_dur[2] = 16'd0; pack();
    bus.req = 4'b0100;
    ew = model_winner(bus.req);
    observe(-1, 1'b1);
    n_checks++; if (o_done !== 4'b0100) begin n_fail++; $display("FAIL dur0_done: got %b want 0100", o_done); end
    n_checks++; if (o_en !== 0 || o_ticks !== 0) begin n_fail++; $display("FAIL dur0_gen_en: got en_cycles=%0d ticks=%0d want 0/0", o_en, o_ticks); end
    n_checks++; if (o_duty !== 8'd200) begin n_fail++; $display("FAIL dur0_duty: got %0d want 200", o_duty); end
    m_ptr = (ew + 1) % NR; m_lat = 3;
  endtask

  task automatic test_abort();
    int ew;
    f_duty[0] = 8'd11; f_div[0] = 16'd300; f_dur[0] = 16'd5;
    f_duty[1] = 8'd22; f_div[1] = 16'd400; f_dur[1] = 16'd2; pack();
    tick_per = 3;
    bus.req = 4'b0011;
    ew = model_winner(bus.req);
    observe(2, 1'b1);
    n_checks++; if (o_grant !== onehot(ew)) begin n_fail++; $display("FAIL abort_grant: got %b want %b", o_grant, onehot(ew)); end
    n_checks++; if (o_abort !== 1'b1 || o_done !== 4'b0000) begin n_fail++; $display("FAIL abort_no_done: got abort=%0b done=%b want 1/0000", o_abort, o_done); end
    n_checks++; if (o_ticks !== 3) begin n_fail++; $display("FAIL abort_ticks: got %0d want 3", o_ticks); end
    n_checks++; if (bus.gen_en !== 1'b0 || bus.grant !== 4'b0000) begin n_fail++; $display("FAIL abort_release: got en=%b grant=%b want 0/0000", bus.gen_en, bus.grant); end
    m_ptr = (ew + 1) % NR; m_lat = 2;
    ew = model_winner(bus.req);
    observe(-1, 1'b1);
    n_checks++; if (o_grant !== 4'b0010 || o_grant !== onehot(ew)) begin n_fail++; $display("FAIL abort_next_grant: got %b want 0010", o_grant); end
    n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 2", o_lat); end
    n_checks++; if (o_done !== 4'b0010 || o_ticks !== 2) begin n_fail++; $display("FAIL abort_next_done: got done=%b ticks=%0d want 0010/2", o_done, o_ticks); end
    m_ptr = (ew + 1) % NR; m_lat = 3;
  endtask

  task automatic test_abort_on_last_tick();
    int ew;
    f_duty[0] = 8'd99; f_div[0] = 16'd12; f_dur[0] = 16'd3; pack();
    tick_per = 2;
    bus.req = 4'b0001;
    ew = model_winner(bus.req);
    observe(2, 1'b1);
    n_checks++; if (o_done !== 4'b0001 || o_abort !== 1'b0) begin n_fail++; $display("FAIL last_tick_done: got done=%b abort=%0b want 0001/0", o_done, o_abort); end
    n_checks++; if (o_ticks !== 3) begin n_fail++; $display("FAIL last_tick_ticks: got %0d want 3", o_ticks); end
    m_ptr = (ew + 1) % NR; m_lat = 3;
  endtask

  task automatic test_reset_mid_run();
    int cnt, k, ew;
    bit seen_done;
    cyc(); cyc();
    f_duty[2] = 8'd50; f_div[2] = 16'd9; f_dur[2] = 16'd5; pack();
    tick_per = 2;
    bus.req = 4'b0100;
    cnt = 0; k = 0; seen_done = 0;
    while (cnt < 2 && k < 200) begin
      if (bus.gen_en && bus.gen_period_tick) cnt++;
      cyc(); k++;
      if (bus.done != '0) seen_done = 1;
    end
    n_checks++; if (cnt !== 2) begin n_fail++; $display("FAIL midrun_reach_run: got ticks=%0d want 2", cnt); end
    reset = 1'b1; bus.req = '0;
    cyc();
    n_checks++;
    if ({bus.grant, bus.done, bus.busy, bus.gen_load, bus.gen_en, bus.gen_duty, bus.gen_div} !== '0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got grant=%b done=%b busy=%b load=%b en=%b duty=%0d div=%0d want all 0",
        bus.grant, bus.done, bus.busy, bus.gen_load, bus.gen_en, bus.gen_duty, bus.gen_div);
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrun_no_done: got %0b want 0", seen_done); end
    reset = 1'b0; m_ptr = 0; m_lat = 2;
    f_duty[1] = 8'd1; f_div[1] = 16'd2; f_dur[1] = 16'd1;
    f_duty[3] = 8'd3; f_div[3] = 16'd4; f_dur[3] = 16'd1; pack();
    bus.req = 4'b1010;
    ew = model_winner(bus.req);
    observe(-1, 1'b1);
    n_checks++; if (o_grant !== 4'b0010 || o_grant !== onehot(ew)) begin n_fail++; $display("FAIL midrun_restart_grant: got %b want 0010", o_grant); end
    m_ptr = (ew + 1) % NR; m_lat = 3;
    bus.req = '0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_random();
    logic [NR-1:0] nr;
    int ew, drop, exp_ticks;
    bit exp_abort;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      nr = NR'($urandom_range(0, 15));
      if ((bus.req | nr) == '0) nr = onehot(int'($urandom_range(0, NR - 1)));
      for (int j = 0; j < NR; j++) begin
        if (nr[j] && !bus.req[j]) begin
          f_duty[j] = BW'($urandom); f_div[j] = DW'($urandom); f_dur[j] = UW'($urandom_range(0, 4));
        end
      end
      pack();
      bus.req = bus.req | nr;
      tick_per = int'($urandom_range(1, 4));
      ew = model_winner(bus.req);
      drop = -1;
      if (f_dur[ew] != 16'd0 && $urandom_range(0, 3) == 0) drop = int'($urandom_range(0, int'(f_dur[ew]) - 1));
      exp_abort = (drop >= 0) && (drop < int'(f_dur[ew]) - 1);
      exp_ticks = exp_abort ? drop + 1 : int'(f_dur[ew]);
      observe(drop, 1'b1);
      n_checks++; if (o_tmo !== 1'b0) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %0b want 0", it, o_tmo); end
      n_checks++; if (o_grant !== onehot(ew)) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b want %b", it, o_grant, onehot(ew)); end
      n_checks++; if (o_lat !== m_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, o_lat, m_lat); end
      n_checks++; if (o_duty !== f_duty[ew] || o_div !== f_div[ew]) begin
        n_fail++; $display("FAIL rand_config[%0d]: got duty=%0d div=%0d want %0d/%0d", it, o_duty, o_div, f_duty[ew], f_div[ew]); end
      n_checks++; if (o_ticks !== exp_ticks) begin n_fail++; $display("FAIL rand_ticks[%0d]: got %0d want %0d", it, o_ticks, exp_ticks); end
      n_checks++; if (o_abort !== exp_abort || o_done !== (exp_abort ? 4'b0000 : onehot(ew))) begin
        n_fail++; $display("FAIL rand_outcome[%0d]: got abort=%0b done=%b want %0b/%b", it, o_abort, o_done, exp_abort, exp_abort ? 4'b0000 : onehot(ew)); end
      if (!exp_abort && exp_ticks > 0) begin
        n_checks++; if (o_gap !== 1) begin n_fail++; $display("FAIL rand_done_delay[%0d]: got %0d want 1", it, o_gap); end
      end
      m_ptr = (ew + 1) % NR;
      m_lat = exp_abort ? 2 : 3;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.req_duty = '0; bus.req_div = '0; bus.req_dur = '0;
    bus.gen_period_tick = 1'b0;
    for (int j = 0; j < NR; j++) begin f_duty[j] = '0; f_div[j] = '0; f_dur[j] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_dur_zero();
    test_abort();
    test_abort_on_last_tick();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_tone_scheduler.md
# pwm_tone_scheduler

Time-shares one pulse-width-modulation tone generator between `NUM_REQ` requesters. Each requester posts a duty value, a time-base divider and a duration counted in whole PWM periods. The scheduler arbitrates between requesters, loads the winner's configuration into the generator, runs it for the requested number of periods, then releases it. It sits between the control/sequencer logic and the PWM generator in the audio output path.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `BIT_WIDTH`, 8, duty/resolution width of the shared generator
- `DIV_W`, 16, width of the time-base divider field
- `DUR_W`, 16, width of the duration field, in PWM periods

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req`  in  NUM_REQ  per-requester request level
- `req_duty`  in  NUM_REQ*BIT_WIDTH  packed duty values; requester i occupies `[i*BIT_WIDTH +: BIT_WIDTH]`
- `req_div`  in  NUM_REQ*DIV_W  packed clock counts per PWM resolution step
- `req_dur`  in  NUM_REQ*DUR_W  packed durations in PWM periods
- `gen_period_tick`  in  1  generator's one-cycle pulse at each PWM period wrap
- `grant`  out  NUM_REQ  one-hot owner of the generator; 0 when idle
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner
- `busy`  out  1  high in every state except IDLE
- `gen_load`  out  1  one-cycle configuration strobe to the generator
- `gen_en`  out  1  generator run enable
- `gen_duty`  out  BIT_WIDTH  registered duty value
- `gen_div`  out  DIV_W  registered divider value

## Operation
- FSM states: IDLE, ARB, LOAD, RUN, DONE.
- **IDLE:** go to ARB when any `req` bit is high.
- **ARB:** select the winner round-robin, starting from the round-robin pointer `rr_ptr`. Latch the winner's duty, divider and duration. If `req` is all-zero by this cycle, return to IDLE.
- **LOAD:**
  - Assert `grant[w]` and pulse `gen_load` with `gen_duty`/`gen_div` valid.
  - Set `rr_ptr` to (w+1) mod NUM_REQ.
  - Clear the period counter.
  - Go to DONE if the duration is 0; otherwise go to RUN.
- **RUN:**
  - `gen_en`=1.
  - Each `gen_period_tick` increments the period counter.
  - On the tick where counter+1 == duration, go to DONE.
- **Abort:** `req[w]` low in RUN means the run stops at the next `gen_period_tick` (clean period boundary). The FSM then returns to IDLE with no `done` pulse.
- **Tick and abort in the same cycle:**
  - If that tick is the completing tick, completion wins: DONE and a `done` pulse.
  - Otherwise the abort proceeds to IDLE.
- **DONE:** `done[w]`=1 for one cycle. `grant` and `gen_en` are 0. Go to IDLE.
- **Requester rule:** fields must stay stable from `req` rise until `grant`. The requester drops `req` on `done`. If `req` is still high after `done`, it re-enters arbitration behind the others.
- Non-owner `req` changes never affect a run in progress.
- Duration counter is `DUR_W` bits and never wraps. The maximum run is 2^DUR_W−1 periods.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `gen_load`=0, `gen_en`=0, `gen_duty`=0, `gen_div`=0, `rr_ptr`=0, state IDLE.
- Reset mid-operation: the next edge forces all reset values, with no `done` pulse.
- All outputs are registered.
- `req` rising with the FSM in IDLE at edge T gives:
  - ARB at T+1;
  - LOAD at T+2, with `grant`, `gen_load` and config valid;
  - `gen_en` high from T+3.
- `gen_period_tick` is ignored in LOAD.
- Completing tick at edge K gives: DONE at K+1; IDLE at K+2; earliest next `gen_load` at K+4.
- A duration of N consumes exactly N ticks in RUN.

## Configuration
- `PWM_SCHED_FIXED_PRIO_EN`
  - Defined: ARB uses fixed priority, lowest index wins, and `rr_ptr` is unused (held at 0).
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then `req`=4'b0001 with duty 8'd64, div 16'd195, dur 16'd3:
  - `grant`=0001 and `gen_load` pulse 2 cycles after `req`;
  - `gen_en` spans exactly 3 ticks;
  - `done`=0001 one cycle after the 3rd tick.
- `req`=4'b1111 held, each requester dur 1:
  - grant order 0,1,2,3,0;
  - with `PWM_SCHED_FIXED_PRIO_EN` defined, the order is 0,0,0 while `req[0]` stays high.
- Dur 0 on requester 2: LOAD → DONE; `done`=0100; `gen_en` never asserts.
- Owner drops `req` after 2 of 5 ticks:
  - `gen_en` falls after the next tick;
  - no `done` pulse;
  - next requester granted.
- Owner drops `req` in the same cycle as the completing tick: `done` pulses.
- Reset asserted mid-RUN: all outputs 0 next cycle, no `done`, next arbitration starts from index 0.
